serial_adder_ctrl: RTL and testbench

- Multi-cycle bit-serial add/subtract unit. It time-shares a single 1-bit full-adder cell, built from two Half_adder instances plus an OR, across the WIDTH bit positions of the operands.
- It is used as a low-area arithmetic resource for slow paths such as the multi-cycle ALU fallback and address-offset computation.
- Handshake to the issuing stage is start/ready/done.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_adder_cell.sv | 39 +++
 rtl/half_adder.sv | 19 +
 rtl/serial_adder_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared encodings for the bit-serial add/subtract controller.
//   sa_state_t : controller FSM states (IDLE / RUN / DONE)
//   SA_OP_*    : op_sub encodings sampled with start
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_t;

  localparam logic SA_OP_ADD = 1'b0;
  localparam logic SA_OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Combinational 1-bit full adder built from two half adders; the two partial
// carries can never both be 1, so an OR merges them.
// Ports:
//   x, y : operand bits
//   cin  : carry in
//   s    : sum out
//   cout : carry out
// -----------------------------------------------------------------------------
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .x (x),
    .y (y),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .x (s0),
    .y (cin),
    .s (s),
    .c (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// Combinational 1-bit half adder.
// Ports:
//   x, y : input bits
//   s    : sum  (x ^ y)
//   c    : carry (x & y)
// -----------------------------------------------------------------------------
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Multi-cycle bit-serial add/subtract unit. One full_adder_cell is time-shared
// across the WIDTH bit positions, LSB first, one bit per clock.
//
// Optional feature (macro SERIAL_ADDER_EARLY_EXIT_EN): when defined, RUN ends
// as soon as the carry is 0 and all remaining operand bits are 0; the untouched
// upper result bits stay 0 and carry_out/overflow are 0.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request, accepted only while ready=1
//   op_sub    : 0 = a+b, 1 = a-b (sampled with start)
//   a, b      : operands (sampled with start)
//   ready     : high in IDLE
//   busy      : high in RUN
//   done      : one-cycle pulse when result is valid
//   result    : sum/difference, held until the next accepted start
//   carry_out : carry out of the MSB (sub: 1 = no borrow)
//   overflow  : signed overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] IDX_MSB    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] IDX_MSB_IN = CNT_W'(WIDTH - 2);

  sa_state_t        state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtraction
  logic             carry_q;
  logic             carry_msb_in;
  logic [CNT_W-1:0] idx;

  logic fa_s;
  logic fa_cout;
  logic early_exit;

  full_adder_cell u_fa (
    .x    (a_q[idx]),
    .y    (b_q[idx]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

`ifdef SERIAL_ADDER_EARLY_EXIT_EN
  // Nothing left to propagate: every remaining sum bit would be 0.
  assign early_exit = !carry_q && ((a_q >> idx) == '0) && ((b_q >> idx) == '0);
`else
  assign early_exit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SA_IDLE;
      // NOTE: operand registers are reset too; they are a handful of flops,
      // not a memory, and a clean reset image simplifies debug.
      a_q          <= '0;
      b_q          <= '0;
      carry_q      <= 1'b0;
      carry_msb_in <= 1'b0;
      idx          <= '0;
      ready        <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      carry_out    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        SA_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q          <= a;
            b_q          <= (op_sub == SA_OP_SUB) ? ~b : b;
            carry_q      <= op_sub;  // +1 completes the two's complement
            carry_msb_in <= 1'b0;
            result       <= '0;
            idx          <= '0;
            ready        <= 1'b0;
            busy         <= 1'b1;
            state        <= SA_RUN;
          end
        end

        SA_RUN: begin
          if (early_exit) begin
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= SA_DONE;
          end else begin
            result[idx] <= fa_s;
            carry_q     <= fa_cout;
            if (idx == IDX_MSB_IN) begin
              carry_msb_in <= fa_cout;
            end
            if (idx == IDX_MSB) begin
              carry_out <= fa_cout;
              overflow  <= carry_msb_in ^ fa_cout;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= SA_DONE;
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end

        SA_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= SA_IDLE;
        end

        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= SA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Directed bench for serial_adder_ctrl at WIDTH=8. Stimulus pushes expected
// results into a scoreboard queue; a monitor pops and compares on each done.
// Honours SERIAL_ADDER_EARLY_EXIT_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           done_cyc;
    int           runs;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected number of RUN cycles for one operation.
  function automatic int exp_runs(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic sub);
    logic         c;
    logic [W-1:0] bq;
    logic         en;
    c  = sub;
    bq = sub ? ~bb : bb;
`ifdef SERIAL_ADDER_EARLY_EXIT_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    for (int i = 0; i < W; i++) begin
      if (en && !c && ((aa >> i) == '0) && ((bq >> i) == '0)) return i + 1;
      c = (aa[i] & bq[i]) | (c & (aa[i] ^ bq[i]));
    end
    return W;
  endfunction

  // Wait for ready, issue one operation, push its expectation.
  task automatic issue(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic sub, input logic [W-1:0] res, input logic co, input logic ov,
                       input logic chk_hold, input logic [W-1:0] hold_val);
    bit ok;
    int r;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s_ready_timeout: ready never rose within 40 cycles", name);
      return;
    end
    if (chk_hold) check({name, "_hold"}, 64'(result), 64'(hold_val));
    start  = 1'b1;
    a      = aa;
    b      = bb;
    op_sub = sub;
    r      = exp_runs(aa, bb, sub);
    e.res = res; e.co = co; e.ov = ov; e.done_cyc = cyc + 1 + r; e.runs = r; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    op_sub = 1'($urandom);
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: done=1 with result %0h but nothing outstanding", result);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"},    64'(result),    64'(e.res));
          check({e.name, "_carry_out"}, 64'(carry_out), 64'(e.co));
          check({e.name, "_overflow"},  64'(overflow),  64'(e.ov));
          check({e.name, "_latency"},   64'(cyc),       64'(e.done_cyc));
          check({e.name, "_busy_cyc"},  64'(busy_cnt),  64'(e.runs));
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    check("rst_ready",     64'(ready),     64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_carry_out", 64'(carry_out), 64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    rst_n = 1'b1;

    // Reset mid-RUN: aborts at once, no done pulse.
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01; op_sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready",     64'(ready),     64'd1);
    check("abort_busy",      64'(busy),      64'd0);
    check("abort_done",      64'(done),      64'd0);
    check("abort_result",    64'(result),    64'd0);
    check("abort_carry_out", 64'(carry_out), 64'd0);
    check("abort_overflow",  64'(overflow),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_ready", 64'(ready), 64'd1);
    check("post_abort_busy",  64'(busy),  64'd0);

    // Add, wrap and signed overflow.
    issue("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, '0);
    issue("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, '0);
    issue("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    // Subtract: borrow, signed overflow, zero minus one.
    issue("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, '0);
    issue("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, '0);
    issue("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, '0);

    // Handshake: start during RUN is ignored.
    issue("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; op_sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    // Back-to-back on the first ready cycle; previous result must still hold.
    issue("add_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 8'h41);
    issue("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d operations never produced done", sb.size());
    end
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
